// File: rtl/mem_arb_pkg.sv
// Shared constants, channel indices and FSM state encoding for mem_burst_arb.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_LEN_W  = 10;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned N_CH       = 4;

    // Channel indices: two read clients then two write clients
    localparam logic [1:0] CH_RD0 = 2'd0;
    localparam logic [1:0] CH_RD1 = 2'd1;
    localparam logic [1:0] CH_WR0 = 2'd2;
    localparam logic [1:0] CH_WR1 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Index of the set bit of a one-hot channel vector
    function automatic logic [1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 4-way picker: first requesting channel after i_ptr, wrapping 3->0.
// With i_ptr fixed at channel 3 this degenerates to lowest-index-wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [N_CH-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [N_CH-1:0] o_grant
);

    logic [1:0] w_idx;
    logic       w_found;

    // Scan channels ptr+1 .. ptr+4 (mod 4) and keep the first requester
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arb.sv
// Four-requester arbiter in front of the single mem_burst controller.
// Two read channels (0,1) and two write channels (2,3) share one burst engine;
// data handshakes are steered combinationally to the granted channel.
// Build option: define MEM_BURST_ARB_RR_EN for round-robin arbitration,
// otherwise fixed priority (rd0 > rd1 > wr0 > wr1).
module mem_burst_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned DATA_W = DEF_DATA_W
)(
    input  logic                  mem_clk,
    input  logic                  rst_n,
    input  logic                  local_initial_done,
    input  logic [N_CH-1:0]       rq_req,
    input  logic [4*ADDR_W-1:0]   rq_addr,
    input  logic [4*LEN_W-1:0]    rq_len,
    input  logic [2*DATA_W-1:0]   rq_wdata,
    output logic [N_CH-1:0]       rq_finish,
    output logic [1:0]            rq_rdata_valid,
    output logic [DATA_W-1:0]     rq_rdata,
    output logic [1:0]            rq_wdata_req,
    output logic [N_CH-1:0]       arb_grant,
    output logic                  arb_busy,
    output logic                  rd_burst_req,
    output logic                  wr_burst_req,
    output logic [ADDR_W-1:0]     rd_burst_addr,
    output logic [ADDR_W-1:0]     wr_burst_addr,
    output logic [LEN_W-1:0]      rd_burst_len,
    output logic [LEN_W-1:0]      wr_burst_len,
    output logic [DATA_W-1:0]     wr_burst_data,
    input  logic                  rd_burst_data_valid,
    input  logic                  wr_burst_data_req,
    input  logic                  burst_finish,
    input  logic [DATA_W-1:0]     rd_burst_data
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [N_CH-1:0]     r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [N_CH-1:0]     w_pick;
    logic [1:0]          w_ptr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LEN_W-1:0]    w_sel_len;
    logic [DATA_W-1:0]   w_wdata_sel;
    logic                w_load;
    logic                w_clr;
    logic                w_rd_grant;
    logic                w_wr_grant;

    assign w_rd_grant = |r_grant[1:0];
    assign w_wr_grant = |r_grant[3:2];

    mem_arb_pick u_pick (
        .i_req   (rq_req),
        .i_ptr   (w_ptr),
        .o_grant (w_pick)
    );

`ifdef MEM_BURST_ARB_RR_EN
    logic [1:0] r_ptr;

    // Round-robin pointer remembers the last granted channel; reset makes channel 0 first
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= CH_WR1;
        end else if (w_load) begin
            r_ptr <= onehot_to_idx(w_pick);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = CH_WR1;
`endif

    // Select the winner's address and length for latching
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_pick[i]) begin
                w_sel_addr = rq_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = rq_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Write data of the granted write channel
    always_comb begin
        w_wdata_sel = r_grant[3] ? rq_wdata[DATA_W +: DATA_W] : rq_wdata[0 +: DATA_W];
    end

    // FSM state register
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, burst strobes and data steering
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_clr          = 1'b0;
        rd_burst_req   = 1'b0;
        wr_burst_req   = 1'b0;
        rq_finish      = '0;
        rq_rdata_valid = '0;
        rq_rdata       = '0;
        rq_wdata_req   = '0;
        wr_burst_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (local_initial_done && (rq_req != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_len == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    rd_burst_req = w_rd_grant;
                    wr_burst_req = w_wr_grant;
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                rq_rdata_valid = {2{rd_burst_data_valid}} & r_grant[1:0];
                rq_rdata       = w_rd_grant ? rd_burst_data : '0;
                rq_wdata_req   = {2{wr_burst_data_req}} & r_grant[3:2];
                wr_burst_data  = w_wr_grant ? w_wdata_sel : '0;
                if (burst_finish) begin
                    rq_finish   = r_grant;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                rq_finish   = r_grant;
                w_clr       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant and burst parameters latched at arbitration, grant dropped on completion
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_addr  <= '0;
            r_len   <= '0;
        end else if (w_load) begin
            r_grant <= w_pick;
            r_addr  <= w_sel_addr;
            r_len   <= w_sel_len;
        end else if (w_clr) begin
            r_grant <= '0;
        end
    end

    assign arb_grant     = r_grant;
    assign arb_busy      = (r_state != ST_IDLE);
    assign rd_burst_addr = r_addr;
    assign wr_burst_addr = r_addr;
    assign rd_burst_len  = r_len;
    assign wr_burst_len  = r_len;

endmodule

// File: tb/tb_mem_burst_arb.sv
// Scoreboard bench for mem_burst_arb with a behavioural mem_burst responder.
// Expected issues/completions are queued by the stimulus and checked by a monitor.
module tb_mem_burst_arb;

    localparam int unsigned AW = 24;
    localparam int unsigned LW = 10;
    localparam int unsigned DW = 64;

    logic              mem_clk;
    logic              rst_n;
    logic              local_initial_done;
    logic [3:0]        rq_req;
    logic [4*AW-1:0]   rq_addr;
    logic [4*LW-1:0]   rq_len;
    logic [2*DW-1:0]   rq_wdata;
    logic [3:0]        rq_finish;
    logic [1:0]        rq_rdata_valid;
    logic [DW-1:0]     rq_rdata;
    logic [1:0]        rq_wdata_req;
    logic [3:0]        arb_grant;
    logic              arb_busy;
    logic              rd_burst_req;
    logic              wr_burst_req;
    logic [AW-1:0]     rd_burst_addr;
    logic [AW-1:0]     wr_burst_addr;
    logic [LW-1:0]     rd_burst_len;
    logic [LW-1:0]     wr_burst_len;
    logic [DW-1:0]     wr_burst_data;
    logic              rd_burst_data_valid;
    logic              wr_burst_data_req;
    logic              burst_finish;
    logic [DW-1:0]     rd_burst_data;

    typedef struct {
        int          ch;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int          cyc;
    } exp_t;

    exp_t iss_q[$];
    exp_t fin_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   fin_seen = 0;
    logic [AW-1:0] ch_addr [4];
    logic [LW-1:0] ch_len  [4];

    mem_burst_arb #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .mem_clk             (mem_clk),
        .rst_n               (rst_n),
        .local_initial_done  (local_initial_done),
        .rq_req              (rq_req),
        .rq_addr             (rq_addr),
        .rq_len              (rq_len),
        .rq_wdata            (rq_wdata),
        .rq_finish           (rq_finish),
        .rq_rdata_valid      (rq_rdata_valid),
        .rq_rdata            (rq_rdata),
        .rq_wdata_req        (rq_wdata_req),
        .arb_grant           (arb_grant),
        .arb_busy            (arb_busy),
        .rd_burst_req        (rd_burst_req),
        .wr_burst_req        (wr_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .wr_burst_addr       (wr_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data       (wr_burst_data),
        .rd_burst_data_valid (rd_burst_data_valid),
        .wr_burst_data_req   (wr_burst_data_req),
        .burst_finish        (burst_finish),
        .rd_burst_data       (rd_burst_data)
    );

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    always @(posedge mem_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] oh4(input int ch);
        logic [3:0] v;
        v = '0;
        v[ch[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l);
        ch_addr[ch] = a;
        ch_len[ch]  = l;
        rq_addr[ch*AW +: AW] = a;
        rq_len[ch*LW +: LW]  = l;
    endtask

    task automatic push_exp(input int ch, input int icyc, input int fcyc);
        exp_t e;
        e.ch   = ch;
        e.addr = ch_addr[ch];
        e.len  = ch_len[ch];
        e.cyc  = icyc;
        if (ch_len[ch] != '0) iss_q.push_back(e);
        e.cyc  = fcyc;
        fin_q.push_back(e);
    endtask

    // Wait for the given completion count, then step to just after the finishing edge
    task automatic wait_fins(input int target, input string name);
        int budget;
        budget = 400;
        while (fin_seen < target && budget > 0) begin
            @(negedge mem_clk);
            #1;
            budget--;
        end
        chk({name, "_done"}, 64'(fin_seen >= target), 64'd1);
        @(posedge mem_clk);
        #1;
    endtask

    // Behavioural mem_burst: one beat per cycle after the request, then burst_finish
    initial begin : mem_model
        int  m_len;
        bit  m_wr;
        bit  m_abort;
        rd_burst_data_valid = 1'b0;
        wr_burst_data_req   = 1'b0;
        burst_finish        = 1'b0;
        rd_burst_data       = '0;
        forever begin
            @(posedge mem_clk);
            #1;
            if (rst_n && (rd_burst_req || wr_burst_req)) begin
                m_wr    = wr_burst_req;
                m_len   = int'(rd_burst_req ? rd_burst_len : wr_burst_len);
                m_abort = 1'b0;
                for (int b = 0; b < m_len; b++) begin
                    @(posedge mem_clk);
                    #1;
                    if (!rst_n) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (m_wr) begin
                        wr_burst_data_req = 1'b1;
                    end else begin
                        rd_burst_data_valid = 1'b1;
                        rd_burst_data       = {$urandom, $urandom};
                    end
                end
                @(posedge mem_clk);
                #1;
                rd_burst_data_valid = 1'b0;
                wr_burst_data_req   = 1'b0;
                if (!m_abort && rst_n) begin
                    burst_finish = 1'b1;
                    @(posedge mem_clk);
                    #1;
                    burst_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: compare issued bursts, steered beats and completions against the queues
    initial begin : monitor
        exp_t          e;
        int            cur_ch;
        bit            cur_valid;
        int            beats;
        logic [1:0]    ev;
        logic [DW-1:0] ed;
        cur_ch    = 0;
        cur_valid = 1'b0;
        beats     = 0;
        forever begin
            @(negedge mem_clk);
            if (!rst_n) begin
                cur_valid = 1'b0;
                beats     = 0;
            end else begin
                if (rd_burst_req || wr_burst_req) begin
                    if (iss_q.size() == 0) begin
                        chk("issue_unexpected", 64'({rd_burst_req, wr_burst_req}), 64'd0);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue_strobe", 64'({rd_burst_req, wr_burst_req}), (e.ch >= 2) ? 64'd1 : 64'd2);
                        chk("issue_rd_addr", 64'(rd_burst_addr), 64'(e.addr));
                        chk("issue_wr_addr", 64'(wr_burst_addr), 64'(e.addr));
                        chk("issue_rd_len", 64'(rd_burst_len), 64'(e.len));
                        chk("issue_wr_len", 64'(wr_burst_len), 64'(e.len));
                        chk("issue_grant", 64'(arb_grant), 64'(oh4(e.ch)));
                        chk("issue_busy", 64'(arb_busy), 64'd1);
                        if (e.cyc >= 0) chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                        cur_ch    = e.ch;
                        cur_valid = 1'b1;
                        beats     = 0;
                    end
                end
                ev = (cur_valid && cur_ch < 2) ? ((cur_ch == 0) ? 2'b01 : 2'b10) : 2'b00;
                if (rd_burst_data_valid) begin
                    chk("rd_valid", 64'(rq_rdata_valid), 64'(ev));
                    chk("rd_data", 64'(rq_rdata), (ev != 2'b00) ? 64'(rd_burst_data) : 64'd0);
                    if (ev != 2'b00) beats++;
                end else begin
                    chk("rd_valid_idle", 64'(rq_rdata_valid), 64'd0);
                end
                ev = (cur_valid && cur_ch >= 2) ? ((cur_ch == 2) ? 2'b01 : 2'b10) : 2'b00;
                if (wr_burst_data_req) begin
                    ed = (ev == 2'b01) ? rq_wdata[DW-1:0] : (ev == 2'b10) ? rq_wdata[2*DW-1:DW] : '0;
                    chk("wr_req", 64'(rq_wdata_req), 64'(ev));
                    chk("wr_data", 64'(wr_burst_data), 64'(ed));
                    if (ev != 2'b00) beats++;
                end else begin
                    chk("wr_req_idle", 64'(rq_wdata_req), 64'd0);
                end
                if (rq_finish != 4'b0000) begin
                    fin_seen++;
                    if (fin_q.size() == 0) begin
                        chk("finish_unexpected", 64'(rq_finish), 64'd0);
                    end else begin
                        e = fin_q.pop_front();
                        chk("finish_ch", 64'(rq_finish), 64'(oh4(e.ch)));
                        chk("finish_beats", 64'(beats), 64'(e.len));
                        if (e.cyc >= 0) chk("finish_cycle", 64'(cyc), 64'(e.cyc));
                    end
                    cur_valid = 1'b0;
                    beats     = 0;
                end
            end
        end
    end

    // Directed stimulus
    initial begin : stim
        int seq [5];
        int base;
        rst_n              = 1'b1;
        local_initial_done = 1'b1;
        rq_req             = '0;
        rq_addr            = '0;
        rq_len             = '0;
        rq_wdata           = {64'hC3C3_3C3C_0F0F_F0F0, 64'hA5A5_5A5A_1234_5678};
        for (int i = 0; i < 4; i++) begin
            ch_addr[i] = '0;
            ch_len[i]  = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge mem_clk);
        #1;
        chk("rst_grant", 64'(arb_grant), 64'd0);
        chk("rst_busy", 64'(arb_busy), 64'd0);
        chk("rst_rd_req", 64'(rd_burst_req), 64'd0);
        chk("rst_wr_req", 64'(wr_burst_req), 64'd0);
        chk("rst_finish", 64'(rq_finish), 64'd0);
        chk("rst_addr", 64'(rd_burst_addr), 64'd0);
        chk("rst_len", 64'(wr_burst_len), 64'd0);
        chk("rst_wdata", 64'(wr_burst_data), 64'd0);
        rst_n = 1'b1;
        @(posedge mem_clk);
        #1;

        // Contention with all four channels held
        set_ch(0, 24'h000010, 10'd2);
        set_ch(1, 24'h000020, 10'd3);
        set_ch(2, 24'h000030, 10'd1);
        set_ch(3, 24'h000040, 10'd2);
`ifdef MEM_BURST_ARB_RR_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        base = fin_seen;
        for (int i = 0; i < 5; i++) push_exp(seq[i], (i == 0) ? cyc + 1 : -1, -1);
        rq_req = 4'b1111;
        wait_fins(base + 5, "contention");
        rq_req = 4'b0000;
        repeat (2) @(posedge mem_clk);
        #1;

        // Single read, 16 beats
        set_ch(0, 24'h000100, 10'd16);
        base = fin_seen;
        push_exp(0, cyc + 1, -1);
        rq_req = 4'b0001;
        wait_fins(base + 1, "single_read");
        rq_req = 4'b0000;
        repeat (2) @(posedge mem_clk);
        #1;

        // Single write, 8 beats on channel 2
        set_ch(2, 24'h002000, 10'd8);
        base = fin_seen;
        push_exp(2, cyc + 1, -1);
        rq_req = 4'b0100;
        wait_fins(base + 1, "single_write");
        rq_req = 4'b0000;
        repeat (2) @(posedge mem_clk);
        #1;

        // Zero-length request on channel 3 never reaches mem_burst
        set_ch(3, 24'h0ABCDE, 10'd0);
        base = fin_seen;
        push_exp(3, -1, cyc + 2);
        rq_req = 4'b1000;
        wait_fins(base + 1, "zero_len");
        rq_req = 4'b0000;
        repeat (2) @(posedge mem_clk);
        #1;

        // Calibration gating
        local_initial_done = 1'b0;
        set_ch(1, 24'h123456, 10'd4);
        rq_req = 4'b0010;
        repeat (6) begin
            @(posedge mem_clk);
            #1;
            chk("gate_grant", 64'(arb_grant), 64'd0);
            chk("gate_busy", 64'(arb_busy), 64'd0);
        end
        base = fin_seen;
        push_exp(1, cyc + 1, -1);
        local_initial_done = 1'b1;
        wait_fins(base + 1, "calib");
        rq_req = 4'b0000;
        repeat (2) @(posedge mem_clk);
        #1;

        // Reset in the middle of a read burst, request still pending
        set_ch(0, 24'h000300, 10'd16);
        push_exp(0, cyc + 1, -1);
        rq_req = 4'b0001;
        repeat (6) @(posedge mem_clk);
        #1;
        chk("midrst_busy_before", 64'(arb_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 64'(arb_grant), 64'd0);
        chk("midrst_busy", 64'(arb_busy), 64'd0);
        chk("midrst_rd_valid", 64'(rq_rdata_valid), 64'd0);
        chk("midrst_rd_req", 64'(rd_burst_req), 64'd0);
        chk("midrst_finish", 64'(rq_finish), 64'd0);
        fin_q.delete();
        repeat (4) @(posedge mem_clk);
        #1;
        base = fin_seen;
        push_exp(0, cyc + 1, -1);
        rst_n = 1'b1;
        wait_fins(base + 1, "midrst_regrant");
        rq_req = 4'b0000;
        repeat (4) @(posedge mem_clk);
        #1;

        chk("issue_queue_empty", 64'(iss_q.size()), 64'd0);
        chk("finish_queue_empty", 64'(fin_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_arb.md
# mem_burst_arb

Four-requester arbiter that shares the single mem_burst controller between two read channels and two write channels (e.g. video capture writer, display reader). Accepts level-held burst requests, picks one winner, issues a one-cycle burst request to mem_burst, steers the data handshakes to the winner, and reports completion on burst_finish. Sits directly between the frame-buffer clients and mem_burst in the mem_clk domain.

## Interface
- ADDR_W, 24, burst start address width
- LEN_W, 10, burst length width (64-bit beats)
- DATA_W, 64, data width
- mem_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- local_initial_done  in  1  DDR calibration done; no grant while low
- rq_req  in  4  level request; [0],[1] read channels, [2],[3] write channels
- rq_addr  in  4*ADDR_W  per-channel start address, slice i = [i*ADDR_W +: ADDR_W]
- rq_len  in  4*LEN_W  per-channel length
- rq_wdata  in  2*DATA_W  write data for channels 2,3
- rq_finish  out  4  one-cycle completion pulse to the granted channel
- rq_rdata_valid  out  2  read beat valid, channels 0,1
- rq_rdata  out  DATA_W  broadcast read data
- rq_wdata_req  out  2  write beat request, channels 2,3
- arb_grant  out  4  one-hot current grant, 0 when idle
- arb_busy  out  1  high in any state except IDLE
- rd_burst_req, wr_burst_req  out  1 each  to mem_burst
- rd_burst_addr, wr_burst_addr  out  ADDR_W  to mem_burst
- rd_burst_len, wr_burst_len  out  LEN_W  to mem_burst
- wr_burst_data  out  DATA_W  to mem_burst
- rd_burst_data_valid, wr_burst_data_req, burst_finish  in  1 each  from mem_burst
- rd_burst_data  in  DATA_W  from mem_burst

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE: if local_initial_done and rq_req!=0, pick winner, register one-hot grant, latch its addr/len into registers -> ISSUE. Else stay.
- ISSUE: latched len==0 -> DONE without touching mem_burst. Else pulse rd_burst_req (grant[1:0]) or wr_burst_req (grant[3:2]) for exactly this cycle -> BUSY.
- BUSY: steer rd_burst_data_valid to rq_rdata_valid[granted], wr_burst_data_req to rq_wdata_req[granted], wr_burst_data = rq_wdata[granted]; others held 0. On burst_finish -> IDLE, rq_finish[granted]=1 same cycle (combinational from burst_finish & grant).
- DONE (zero-length only): rq_finish[granted]=1 -> IDLE.
- Grant cleared on leaving BUSY/DONE. Requester keeps rq_req, addr, len stable until rq_finish, deasserts from next cycle.
- rd/wr burst addr/len outputs driven from latched registers in all states (both buses share them).
- Beats with no grant, or burst_finish outside BUSY, are ignored; state unchanged.

## Timing
- Reset: state IDLE, grant 0, latched addr/len 0, RR pointer to channel 3 (so channel 0 first), all outputs 0.
- Request to burst_req: 2 cycles (IDLE sample, ISSUE pulse).
- burst_finish to next possible ISSUE: 2 cycles (IDLE, ISSUE), guaranteeing mem_burst is back in its IDLE.
- rq_rdata_valid/rq_wdata_req are combinational pass-through; zero added latency on data.
- local_initial_done dropping mid-burst: no effect until back in IDLE; then no new grant.
- Reset asserted mid-burst: immediate return to IDLE, all strobes 0; mem_burst shares rst_n.

## Configuration
- MEM_BURST_ARB_RR_EN defined: round-robin; winner is first requesting channel after last granted index, wrapping 3->0; pointer updates on grant.
- Undefined: fixed priority, lowest index wins (rd0 > rd1 > wr0 > wr1); pointer logic absent.

## Structure
- Package mem_arb_pkg: ADDR_W/LEN_W/DATA_W defaults, channel index constants (CH_RD0..CH_WR1), state enum.
- Sub-module mem_arb_pick: combinational 4-way picker, inputs req and pointer, output one-hot winner; pointer input tied off in fixed-priority build.

## Test plan
- Single read: rq_req=0001, addr 0x000100, len 16 -> rd_burst_req pulse 2 cycles later with addr 0x000100 len 16, 16 rq_rdata_valid[0] beats, rq_finish[0] with burst_finish.
- Single write: rq_req=0100, len 8 -> wr_burst_req pulse, rq_wdata_req[0] mirrors 8 wr_burst_data_req, wr_burst_data equals rq_wdata slice 0.
- Contention: rq_req=1111 held -> RR build grants 0,1,2,3,0; fixed build grants 0 repeatedly.
- Zero length: channel 3 len 0 -> rq_finish[3] 2 cycles after grant, no wr_burst_req.
- Calibration gating: local_initial_done=0 with rq_req=0010 -> no grant; raise -> rd_burst_req 2 cycles later.
- Reset mid-burst: rst_n low during BUSY -> arb_grant, arb_busy, all strobes 0 immediately; pending rq_req re-granted after release.
